dtw_query_writer: RTL and testbench
===================================

Name: dtw_query_writer

Overview:
- Producer side of the DTW source-FIFO protocol. Takes a raw-sample AXI-Stream packet (one packet per read) and writes one framed query into the DTW source FIFO.
- Frame format: one 32-bit query-id word, then exactly SQG_SIZE sample words, each zero-extended from WIDTH bits.
- Short packets are padded to SQG_SIZE samples; long packets are truncated and the excess is drained.
- Sits between the host DMA stream and the source FIFO that feeds dtw_core.

Parameters:
- WIDTH, 16, sample width; low WIDTH bits of each input beat are kept.
- AXIS_WIDTH, 32, input stream data width.
- SQG_SIZE, 250, samples per query frame (>=1).
- PAD_VALUE, 0, WIDTH-bit value written for padded samples.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  permits a new frame to start from IDLE
- qid_load  in  1  pulse; loads qid_init into the qid counter (ignored unless IDLE)
- qid_init  in  32  initial query id
- s_axis_tdata  in  AXIS_WIDTH  raw sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  sample accepted when tvalid&&tready
- s_axis_tlast  in  1  last sample of read
- fifo_wren  out  1  source FIFO write enable
- fifo_full  in  1  source FIFO full
- fifo_data  out  32  source FIFO write data
- busy  out  1  high in any state except IDLE
- query_done  out  1  one-cycle pulse when a frame completes
- n_queries  out  32  completed frames
- n_padded  out  32  frames that needed padding
- n_truncated  out  32  frames with excess samples dropped

Behaviour:
- Registered state; fifo_wren, fifo_data and s_axis_tready are combinational from state and inputs. A FIFO write happens in the same cycle as the decision, and never when fifo_full=1.
- Reset: state=IDLE, qid=0, cnt=0, all counters=0. query_done=0, fifo_wren=0, tready=0, busy=0. A reset mid-frame abandons the frame and does not clean up the FIFO; the owner clears it.
- IDLE:
  - tready=0.
  - qid_load=1 sets qid to qid_init; this takes priority over starting a frame in the same cycle.
  - enable=1 moves to HDR.
- HDR:
  - If !fifo_full: fifo_wren=1, fifo_data=qid, cnt<=0, go to DATA.
  - Otherwise stall in HDR.
- DATA:
  - tready = !fifo_full.
  - On a handshake: fifo_wren=1, fifo_data={zeros, tdata[WIDTH-1:0]}, cnt<=cnt+1.
  - If cnt==SQG_SIZE-1: go to DONE when tlast=1, otherwise to DRAIN.
  - Else if tlast=1: go to PAD.
- PAD:
  - tready=0.
  - If !fifo_full: fifo_wren=1, fifo_data=PAD_VALUE zero-extended, cnt<=cnt+1.
  - The write with cnt==SQG_SIZE-1 moves to DONE.
  - n_padded increments once, on entry.
- DRAIN:
  - tready=1, no FIFO writes; beats are discarded.
  - Go to DONE on a handshake with tlast=1.
  - n_truncated increments once, on entry.
- DONE: query_done=1 for this single cycle, qid<=qid+1 (wraps mod 2^32), n_queries+1, then IDLE.
- Every frame therefore writes exactly SQG_SIZE+1 words.
- Counters are 32-bit and wrap.
- cnt width is clog2(SQG_SIZE+1).
- enable dropping mid-frame has no effect; the frame completes.
- fifo_full toggling stalls without losing or duplicating a word.
- SQG_SIZE=1: the first DATA beat is the final sample.

Decomposition:
- dtw_pkg holds:
  - the writer state encodings IDLE/HDR/DATA/PAD/DRAIN/DONE (3 bits);
  - frame header word count (1);
  - a sample zero-extension function.
- Single flat module; no sub-module is needed.

Test Plan (SQG_SIZE=4, PAD_VALUE=0):
- qid_load with qid_init=0x10, then a 4-beat packet 1,2,3,4 with tlast on the 4th -> FIFO receives 0x10,1,2,3,4; one query_done; n_queries=1, n_padded=0, n_truncated=0.
- 2-beat packet 7,8 -> FIFO receives 0x11,7,8,0,0; n_padded=1; tready stays low during the pads.
- 6-beat packet 1..6 -> FIFO receives 0x12,1,2,3,4; beats 5 and 6 accepted and dropped; n_truncated=1; done after beat 6.
- 4-beat packet with fifo_full held high for 3 cycles at the header and 2 cycles mid-data -> no write while full, exactly 5 words written, data order intact.
- Assert rst in the middle of the data beats, then send a 4-beat packet -> state IDLE, counters 0, next frame header = 0x0.
- tdata=0xABCD1234 -> fifo_data=0x00001234.

Source files
------------

// File: rtl/dtw_query_writer_pkg.sv
// Shared definitions for the DTW query writer: FSM encodings, frame layout
// constants and the sample zero-extension helper.
package dtw_query_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } wr_state_e;

  localparam int HDR_WORDS  = 1;
  localparam int FIFO_WIDTH = 32;

  // Keeps the low 'width' bits of a raw word and clears everything above.
  function automatic logic [31:0] zext_sample(input logic [31:0] raw, input int unsigned width);
    logic [31:0] mask;
    if (width >= 32) mask = '1;
    else             mask = (32'h1 << width) - 32'h1;
    return raw & mask;
  endfunction

endpackage

// File: rtl/dtw_query_writer_if.sv
// Raw-sample stream in and source-FIFO write port out, bundled for the writer.
// master = the query writer, slave = the environment (DMA stream + FIFO).
interface dtw_query_writer_if #(
  parameter int AXIS_WIDTH = 32
);
  logic [AXIS_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic                  fifo_wren;
  logic                  fifo_full;
  logic [31:0]           fifo_data;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full,
    output s_axis_tready, fifo_wren, fifo_data
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full,
    input  s_axis_tready, fifo_wren, fifo_data
  );
endinterface

// File: rtl/dtw_query_writer.sv
// Frames one raw-sample packet into a query (id word + SQG_SIZE samples) for the
// DTW source FIFO, padding short packets and draining long ones.
module dtw_query_writer
  import dtw_query_writer_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter int              AXIS_WIDTH = 32,
  parameter int              SQG_SIZE   = 250,
  parameter logic [WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                qid_load,
  input  logic [31:0]         qid_init,
  dtw_query_writer_if.master  bus,
  output logic                busy,
  output logic                query_done,
  output logic [31:0]         n_queries,
  output logic [31:0]         n_padded,
  output logic [31:0]         n_truncated
);

  localparam int CNT_W = $clog2(SQG_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SQG_SIZE - 1);

  wr_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            qid_q, qid_d;
  logic [31:0]            n_queries_q, n_queries_d;
  logic [31:0]            n_padded_q, n_padded_d;
  logic [31:0]            n_truncated_q, n_truncated_d;

  logic                   tready;
  logic                   wren;
  logic [FIFO_WIDTH-1:0]  wdata;
  logic [31:0]            beat_low;
  logic                   handshake;

  if (AXIS_WIDTH >= 32) begin : g_wide_beat
    assign beat_low = bus.s_axis_tdata[31:0];
  end else begin : g_narrow_beat
    assign beat_low = 32'(bus.s_axis_tdata);
  end

  assign handshake = bus.s_axis_tvalid && tready;

  // FIFO writes are decided in the same cycle they are issued, so the stall
  // on fifo_full has to be folded into every write and every tready.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    qid_d         = qid_q;
    n_queries_d   = n_queries_q;
    n_padded_d    = n_padded_q;
    n_truncated_d = n_truncated_q;
    tready        = 1'b0;
    wren          = 1'b0;
    wdata         = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (qid_load)    qid_d   = qid_init;
        else if (enable) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (!bus.fifo_full) begin
          wren    = 1'b1;
          wdata   = qid_q;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tready = !bus.fifo_full;
        if (handshake) begin
          wren  = 1'b1;
          wdata = zext_sample(beat_low, WIDTH);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            if (bus.s_axis_tlast) begin
              state_d = ST_DONE;
            end else begin
              state_d       = ST_DRAIN;
              n_truncated_d = n_truncated_q + 32'd1;
            end
          end else if (bus.s_axis_tlast) begin
            state_d    = ST_PAD;
            n_padded_d = n_padded_q + 32'd1;
          end
        end
      end
      ST_PAD: begin
        if (!bus.fifo_full) begin
          wren  = 1'b1;
          wdata = zext_sample(32'(PAD_VALUE), WIDTH);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        tready = 1'b1;
        if (handshake && bus.s_axis_tlast) state_d = ST_DONE;
      end
      ST_DONE: begin
        qid_d       = qid_q + 32'd1;
        n_queries_d = n_queries_q + 32'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      qid_q         <= '0;
      n_queries_q   <= '0;
      n_padded_q    <= '0;
      n_truncated_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      qid_q         <= qid_d;
      n_queries_q   <= n_queries_d;
      n_padded_q    <= n_padded_d;
      n_truncated_q <= n_truncated_d;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.fifo_wren     = wren;
  assign bus.fifo_data     = wdata;

  assign busy        = (state_q != ST_IDLE);
  assign query_done  = (state_q == ST_DONE);
  assign n_queries   = n_queries_q;
  assign n_padded    = n_padded_q;
  assign n_truncated = n_truncated_q;

endmodule

// File: tb/tb_dtw_query_writer.sv
// Directed, table-driven bench for dtw_query_writer with SQG_SIZE=4, PAD_VALUE=0:
// each record is one packet plus the five FIFO words and counters it must produce.
module tb_dtw_query_writer;

  localparam int WIDTH      = 16;
  localparam int AXIS_WIDTH = 32;
  localparam int SQG_SIZE   = 4;
  localparam int N_VEC      = 7;

  typedef struct packed {
    logic             reset_first;
    logic [3:0]       n_beats;
    logic [7:0][31:0] beats;
    logic [31:0]      full_mask;
    logic [4:0][31:0] exp_words;
    logic [31:0]      exp_nq;
    logic [31:0]      exp_np;
    logic [31:0]      exp_nt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        qid_load;
  logic [31:0] qid_init;
  logic        busy;
  logic        query_done;
  logic [31:0] n_queries;
  logic [31:0] n_padded;
  logic [31:0] n_truncated;

  int          n_checks;
  int          n_fail;
  logic [31:0] cap[$];
  vec_t        vecs[N_VEC];

  dtw_query_writer_if #(.AXIS_WIDTH(AXIS_WIDTH)) bus ();

  dtw_query_writer #(
    .WIDTH     (WIDTH),
    .AXIS_WIDTH(AXIS_WIDTH),
    .SQG_SIZE  (SQG_SIZE),
    .PAD_VALUE ('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .qid_load   (qid_load),
    .qid_init   (qid_init),
    .bus        (bus.master),
    .busy       (busy),
    .query_done (query_done),
    .n_queries  (n_queries),
    .n_padded   (n_padded),
    .n_truncated(n_truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every word the DUT writes is captured; a write while full is an error.
  always @(negedge clk) begin
    if (!rst && bus.fifo_wren) begin
      cap.push_back(bus.fifo_data);
      check_output("no_write_while_full", {31'b0, bus.fifo_full}, 32'h0);
    end
  end

  function automatic vec_t mk(input logic rf, input int n,
                              input logic [31:0] b0, b1, b2, b3, b4, b5,
                              input logic [31:0] fm,
                              input logic [31:0] w0, w1, w2, w3, w4,
                              input logic [31:0] nq, np, nt);
    vec_t v;
    v = '0;
    v.reset_first = rf;
    v.n_beats     = 4'(n);
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2;
    v.beats[3] = b3; v.beats[4] = b4; v.beats[5] = b5;
    v.full_mask = fm;
    v.exp_words[0] = w0; v.exp_words[1] = w1; v.exp_words[2] = w2;
    v.exp_words[3] = w3; v.exp_words[4] = w4;
    v.exp_nq = nq; v.exp_np = np; v.exp_nt = nt;
    return v;
  endfunction

  task automatic drive_beat(input vec_t v, input int idx);
    bus.s_axis_tvalid = (idx < int'(v.n_beats));
    bus.s_axis_tdata  = (idx < 8) ? v.beats[idx] : 32'h0;
    bus.s_axis_tlast  = (idx == int'(v.n_beats) - 1);
  endtask

  // Starts a frame from IDLE (enable for one cycle only) and feeds the packet,
  // following the per-cycle fifo_full mask, until query_done is seen.
  task automatic apply_stimulus(input vec_t v, output int done_cnt, output int rdy_after_last);
    int   idx;
    int   cyc;
    logic seen_done;
    logic after_last;
    logic hs;
    idx = 0; cyc = 0; seen_done = 1'b0; after_last = 1'b0;
    done_cnt = 0; rdy_after_last = 0;
    enable = 1'b1;
    bus.fifo_full = v.full_mask[0];
    drive_beat(v, idx);
    while (!seen_done && cyc < 60) begin
      @(negedge clk);
      hs = bus.s_axis_tvalid && bus.s_axis_tready;
      if (after_last && bus.s_axis_tready) rdy_after_last++;
      if (query_done) begin
        done_cnt++;
        seen_done = 1'b1;
      end
      if (hs && bus.s_axis_tlast) after_last = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      if (hs) idx++;
      drive_beat(v, idx);
      cyc++;
      bus.fifo_full = (cyc < 32) ? v.full_mask[cyc] : 1'b0;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.fifo_full     = 1'b0;
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL frame_timeout: no query_done within 60 cycles");
    end
    @(negedge clk);
    if (query_done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    int rdy_after_last;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = mk(0, 4, 1, 2, 3, 4, 0, 0, 32'h0,
                 32'h10, 1, 2, 3, 4, 1, 0, 0);
    vecs[1] = mk(0, 2, 7, 8, 0, 0, 0, 0, 32'h0,
                 32'h11, 7, 8, 0, 0, 2, 1, 0);
    vecs[2] = mk(0, 6, 1, 2, 3, 4, 5, 6, 32'h0,
                 32'h12, 1, 2, 3, 4, 3, 1, 1);
    vecs[3] = mk(0, 4, 32'hA, 32'hB, 32'hC, 32'hD, 0, 0, 32'h18E,
                 32'h13, 32'hA, 32'hB, 32'hC, 32'hD, 4, 1, 1);
    vecs[4] = mk(0, 4, 32'hABCD1234, 32'hFFFF0001, 32'h00005678, 32'h1234FFFF, 0, 0, 32'h0,
                 32'h14, 32'h1234, 32'h0001, 32'h5678, 32'hFFFF, 5, 1, 1);
    vecs[5] = mk(0, 1, 9, 0, 0, 0, 0, 0, 32'h0,
                 32'h15, 9, 0, 0, 0, 6, 2, 1);
    vecs[6] = mk(1, 4, 32'h21, 32'h22, 32'h23, 32'h24, 0, 0, 32'h0,
                 32'h0, 32'h21, 32'h22, 32'h23, 32'h24, 1, 0, 0);

    rst = 1'b1; enable = 1'b0; qid_load = 1'b0; qid_init = 32'h0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy",        {31'b0, busy},              32'h0);
    check_output("reset_query_done",  {31'b0, query_done},        32'h0);
    check_output("reset_fifo_wren",   {31'b0, bus.fifo_wren},     32'h0);
    check_output("reset_tready",      {31'b0, bus.s_axis_tready}, 32'h0);
    check_output("reset_n_queries",   n_queries,   32'h0);
    check_output("reset_n_padded",    n_padded,    32'h0);
    check_output("reset_n_truncated", n_truncated, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // qid_load and enable together: the load wins and no frame starts.
    qid_load = 1'b1; qid_init = 32'h10; enable = 1'b1;
    @(posedge clk);
    #1;
    qid_load = 1'b0; enable = 1'b0;
    @(negedge clk);
    check_output("load_priority_busy", {31'b0, busy}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < N_VEC; i++) begin
      if (vecs[i].reset_first) begin
        enable = 1'b1;
        bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'h5; bus.s_axis_tlast = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; enable = 1'b0; bus.s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("midreset_busy",        {31'b0, busy}, 32'h0);
        check_output("midreset_n_queries",   n_queries,     32'h0);
        check_output("midreset_n_padded",    n_padded,      32'h0);
        check_output("midreset_n_truncated", n_truncated,   32'h0);
        @(posedge clk);
        #1;
      end
      cap.delete();
      apply_stimulus(vecs[i], done_cnt, rdy_after_last);
      check_output($sformatf("v%0d_word_count", i), 32'(cap.size()), 32'd5);
      for (int w = 0; w < 5; w++)
        check_output($sformatf("v%0d_word%0d", i, w),
                     (w < cap.size()) ? cap[w] : 32'hxxxxxxxx, vecs[i].exp_words[w]);
      check_output($sformatf("v%0d_done_pulses", i),    32'(done_cnt),       32'd1);
      check_output($sformatf("v%0d_tready_after_last", i), 32'(rdy_after_last), 32'd0);
      check_output($sformatf("v%0d_n_queries", i),   n_queries,   vecs[i].exp_nq);
      check_output($sformatf("v%0d_n_padded", i),    n_padded,    vecs[i].exp_np);
      check_output($sformatf("v%0d_n_truncated", i), n_truncated, vecs[i].exp_nt);
      check_output($sformatf("v%0d_idle_after", i),  {31'b0, busy}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
